// File: rtl/alu_pkg.sv
// Shared definitions for the ADD/NOT round-robin arbiter: default width,
// opcode encoding (matches the datapath mux select) and FSM state encoding.
package alu_pkg;

  localparam int N = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_NOT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester handshakes, response outputs and the shared-datapath
// connection. The slave modport is the arbiter's view; master is the view of
// the surrounding requesters and the datapath instance.
interface alu_rr_arbiter_if #(
  parameter int N = alu_pkg::N
);

  logic         req0_valid;
  logic         req0_ready;
  logic         req0_op;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic         req1_op;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;

  logic         rsp0_valid;
  logic         rsp1_valid;
  logic [N-1:0] rsp_data;

  logic [N-1:0] dp_a;
  logic [N-1:0] dp_b;
  logic         dp_select;
  logic [N-1:0] dp_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    output dp_a, dp_b, dp_select,
    input  dp_result
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    input  dp_a, dp_b, dp_select,
    output dp_result
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker. A lone valid requester wins;
// when both are valid the one that did not win last time is chosen.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Pick one-hot winner (or none) from valids and the previous winner
  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one external ADD/NOT datapath between
// two requesters. One operation in flight: IDLE accepts, EXEC gives the
// datapath one full cycle, RESP pulses the owner's response valid.
module alu_rr_arbiter
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  alu_rr_arbiter_if.slave  bus
);

  state_t       state_q,      state_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q,      owner_d;
  logic         op_q,         op_d;
  logic [N-1:0] a_q,          a_d;
  logic [N-1:0] b_q,          b_d;
  logic [N-1:0] rsp_data_q,   rsp_data_d;

  logic [1:0]   grant;
  logic         ready0;
  logic         ready1;

  rr_pick2 u_pick (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Next-state, operand capture and handshake decode
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_data_d   = rsp_data_q;
    ready0       = 1'b0;
    ready1       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The picker only grants a valid requester, so a grant is a transfer.
        if (grant != 2'b00) begin
          ready0       = grant[0];
          ready1       = grant[1];
          owner_d      = grant[1];
          last_grant_d = grant[1];
          op_d         = grant[1] ? bus.req1_op : bus.req0_op;
          a_d          = grant[1] ? bus.req1_a  : bus.req0_a;
          b_d          = grant[1] ? bus.req1_b  : bus.req0_b;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_data_d = bus.dp_result;
        state_d    = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, operand and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= OP_ADD;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // Ready is suppressed while reset is held so nothing is accepted then.
  assign bus.req0_ready = ready0 & ~reset;
  assign bus.req1_ready = ready1 & ~reset;

  assign bus.rsp0_valid = (state_q == S_RESP) && !owner_q && !reset;
  assign bus.rsp1_valid = (state_q == S_RESP) &&  owner_q && !reset;
  assign bus.rsp_data   = rsp_data_q;

  // Operand registers change only on a transfer, so the datapath inputs are
  // stable through EXEC and simply hold their last values elsewhere.
  assign bus.dp_a      = a_q;
  assign bus.dp_b      = b_q;
  assign bus.dp_select = op_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter with a behavioural ADD/NOT datapath.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  alu_rr_arbiter_if bus ();

  alu_rr_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External shared datapath: adder, NOT and 2:1 mux
  assign bus.dp_result = bus.dp_select ? ~bus.dp_a : (bus.dp_a + bus.dp_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE: handshake, EXEC operands, RESP result.
  task automatic run_op(input string tag, input bit r, input logic op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    if (!r) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    #1;
    chk({tag, "_rdy_own"},   {31'd0, r ? bus.req1_ready : bus.req0_ready}, 32'd1);
    chk({tag, "_rdy_other"}, {31'd0, r ? bus.req0_ready : bus.req1_ready}, 32'd0);
    tick();
    if (!r) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    #1;
    chk({tag, "_exec_a"},   bus.dp_a, a);
    chk({tag, "_exec_sel"}, {31'd0, bus.dp_select}, {31'd0, op});
    chk({tag, "_exec_rsp"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    tick();
    chk({tag, "_rsp_vld"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, r ? 32'd2 : 32'd1);
    chk({tag, "_rsp_data"}, bus.rsp_data, exp);
    tick();
    chk({tag, "_idle_rsp"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    bus.req1_valid = 1'b0; bus.req1_op = OP_ADD; bus.req1_a = '0;    bus.req1_b = '0;

    // Reset state (req0 valid held high to show ready is gated)
    tick();
    tick();
    chk("rst_ready",  {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    chk("rst_rsp",    {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    chk("rst_data",   bus.rsp_data, 32'd0);
    chk("rst_dp_a",   bus.dp_a, 32'd0);
    chk("rst_dp_b",   bus.dp_b, 32'd0);
    chk("rst_dp_sel", {31'd0, bus.dp_select}, 32'd0);
    reset = 1'b0;

    // Basic operations, including carry drop
    run_op("add5_7",   1'b0, OP_ADD, 32'd5, 32'd7, 32'd12);
    run_op("not_ffff", 1'b1, OP_NOT, 32'h0000_FFFF, 32'hDEAD_BEEF, 32'hFFFF_0000);
    run_op("add_wrap", 1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);

    // Both valid continuously from reset: grants 0,1,0,1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd10; bus.req0_b = 32'd20;
    bus.req1_valid = 1'b1; bus.req1_op = OP_NOT; bus.req1_a = 32'h1234_5678; bus.req1_b = 32'd0;
    #1;
    chk("both_g0_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    bus.req0_a = 32'd100; bus.req0_b = 32'd1;
    #1;
    chk("both_exec_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    chk("both_r0_vld",  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
    chk("both_r0_data", bus.rsp_data, 32'd30);
    chk("both_resp_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    chk("both_g1_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
    tick();
    bus.req1_a = 32'h0000_0001;
    tick();
    chk("both_r1_vld",  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
    chk("both_r1_data", bus.rsp_data, 32'hEDCB_A987);
    tick();
    chk("both_g2_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    tick();
    chk("both_r2_vld",  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
    chk("both_r2_data", bus.rsp_data, 32'd101);
    tick();
    chk("both_g3_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    chk("both_r3_vld",  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd2);
    chk("both_r3_data", bus.rsp_data, 32'hFFFF_FFFE);
    tick();

    // Reset during EXEC of req0 ADD 3+4: operation dropped
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
    #1;
    chk("rmid_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    tick();
    reset = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_op = OP_NOT; bus.req1_a = 32'hAAAA_0000;
    #1;
    chk("rmid_exec_dp_a", bus.dp_a, 32'd3);
    tick();
    chk("rmid_rsp",    {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    chk("rmid_data",   bus.rsp_data, 32'd0);
    chk("rmid_dp_a",   bus.dp_a, 32'd0);
    chk("rmid_dp_b",   bus.dp_b, 32'd0);
    chk("rmid_ready",  {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    reset = 1'b0;
    run_op("rmid_add3_4", 1'b0, OP_ADD, 32'd3, 32'd4, 32'd7);
    bus.req1_valid = 1'b0;
    #1;

    // Requester 1 arrives during RESP of a req0 op
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd8; bus.req0_b = 32'd9;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req1_valid = 1'b1; bus.req1_op = OP_NOT; bus.req1_a = 32'hF0F0_F0F0; bus.req1_b = 32'd0;
    #1;
    chk("late_resp_vld",  {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd1);
    chk("late_resp_data", bus.rsp_data, 32'd17);
    chk("late_resp_rdy",  {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    run_op("late_not", 1'b1, OP_NOT, 32'hF0F0_F0F0, 32'd0, 32'h0F0F_0F0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one ADD/NOT datapath (adder, bitwise NOT, 2:1 result mux) between two requesters. It accepts one operation at a time over a valid/ready handshake, drives the operands and the mux select to the shared datapath, registers the selected result, and returns it to the requester that issued the operation. It sits between the two issuing blocks and the shared datapath instance.

## Interface
- N, 32, operand and result width in bits

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0's operation is accepted this cycle
- req0_op  in  1  0 = ADD, 1 = NOT
- req0_a, req0_b  in  N  operands; b is ignored for NOT
- req1_valid, req1_ready, req1_op, req1_a, req1_b  —  same as requester 0, for requester 1
- rsp0_valid  out  1  rsp_data holds requester 0's result (one-cycle pulse)
- rsp1_valid  out  1  rsp_data holds requester 1's result (one-cycle pulse)
- rsp_data  out  N  registered result
- dp_a, dp_b  out  N  operands driven to the shared datapath
- dp_select  out  1  mux select: 1 = NOT result, 0 = adder result
- dp_result  in  N  mux output of the shared datapath

## Operation
- Three-state FSM:
  - IDLE: if any reqX_valid is high, grant one requester; assert its reqX_ready combinationally. On the transfer, latch op, a and b into the operand registers and go to EXEC.
  - EXEC: dp_a, dp_b and dp_select are driven from the operand registers. At the end of the cycle, capture dp_result into rsp_data and go to RESP.
  - RESP: pulse rspX_valid for the granted requester for one cycle, then return to IDLE.
- Ready rules:
  - reqX_ready is high only in IDLE, and only for the granted requester.
  - Both ready outputs are never high in the same cycle.
  - A requester that sees ready low holds valid and its payload stable.
- Arbitration:
  - A one-bit last_grant register records the most recent winner.
  - When both requesters are valid, the requester that is not last_grant wins.
  - A single valid requester always wins.
  - last_grant updates only on an accepted transfer.
- Arithmetic:
  - ADD: dp_result = a + b modulo 2^N; carry-out is discarded.
  - NOT: dp_result = ~a.
  - The block does no arithmetic itself. It only forwards dp_result.
- Outputs dp_a, dp_b and dp_select hold their last values outside EXEC; downstream ignores them.
- rsp_data holds its value until the next capture.

## Timing
- Reset values:
  - State = IDLE, last_grant = 1 (requester 0 has first priority).
  - req0_ready = 0 and req1_ready = 0 during reset.
  - rsp0_valid = rsp1_valid = 0.
  - rsp_data = 0, dp_a = dp_b = 0, dp_select = 0.
- Latency: a transfer in cycle t produces rspX_valid in cycle t+2.
- Throughput: one operation per 3 cycles. The next transfer is earliest at cycle t+3.
- The shared datapath must settle within one clk period; EXEC gives it exactly one cycle.
- A valid that arrives during EXEC or RESP waits, with ready low, until the next IDLE.
- Simultaneous valids in IDLE: exactly one is granted per the round-robin rule. The loser stays pending and wins the following IDLE if it is still valid.
- Reset asserted mid-operation: the in-flight operation is dropped and no rspX_valid is issued. All outputs return to their reset values on the next edge.
- A valid that deasserts in IDLE without a handshake is simply not granted. No state changes.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD = 1'b0 and OP_NOT = 1'b1, which match the mux select encoding;
  - state encodings S_IDLE, S_EXEC, S_RESP;
  - default width N = 32.
- One natural sub-module: rr_pick2. It is a combinational two-way round-robin picker with inputs valid[1:0] and last_grant, and outputs grant[1:0] (one-hot or zero).
- The FSM, the operand/result registers and last_grant live in alu_rr_arbiter.
- The datapath (adder, NOT, mux) is instantiated outside the block.

## Test plan
- Reset, then requester 0 sends ADD a=5, b=7 -> req0_ready in the same cycle; rsp0_valid 2 cycles later with rsp_data = 12; rsp1_valid stays 0.
- Requester 1 sends NOT a=32'h0000_FFFF -> rsp1_valid with rsp_data = 32'hFFFF_0000; dp_select = 1 during EXEC.
- Requester 0 sends ADD a=32'hFFFF_FFFF, b=1 -> rsp_data = 0; the carry is dropped.
- Both requesters valid continuously from reset -> grants alternate 0,1,0,1. Transfers occur every 3 cycles, and each rspX_valid matches its requester's operands.
- Reset pulsed during EXEC of req0 ADD 3+4 -> no rsp0_valid. Next cycle: all outputs are 0, state is IDLE, requester 0 is granted first again.
- Requester 1 raises valid during RESP of a req0 operation -> req1_ready stays low until IDLE, then is granted. Its payload is held stable and is correctly computed.
